// File: rtl/lisp_pkg.sv
// Shared Lisp cell definitions: tag constants, field-count lookup and fetch FSM states.
// Used by cell_fetch and lisp_tag_decode.
package lisp;

    localparam int TAG_W      = 8;
    localparam int MAX_FIELDS = 3;
    localparam int CNT_W      = 2;

    localparam logic [TAG_W-1:0] NIL            = 8'h00;
    localparam logic [TAG_W-1:0] TYPE_NUMBER    = 8'h01;
    localparam logic [TAG_W-1:0] TYPE_CONS      = 8'h02;
    localparam logic [TAG_W-1:0] TYPE_FUNC_PRIM = 8'h03;
    localparam logic [TAG_W-1:0] PRIM_CONS      = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        DECODE,
        FIELD,
        DONE
    } fetch_state_t;

    typedef struct packed {
        logic             known;
        logic [CNT_W-1:0] count;
    } field_info_t;

    // Unknown tags report count 0 so an unchecked build treats them as empty cells.
    function automatic field_info_t field_count(input logic [TAG_W-1:0] tag);
        field_info_t info;
        info.known = 1'b1;
        case (tag)
            NIL:            info.count = 2'd0;
            TYPE_NUMBER:    info.count = 2'd1;
            TYPE_CONS:      info.count = 2'd2;
            TYPE_FUNC_PRIM: info.count = 2'd3;
            default: begin
                info.known = 1'b0;
                info.count = 2'd0;
            end
        endcase
        return info;
    endfunction

endpackage

// File: rtl/lisp_tag_decode.sv
// Combinational tag decoder: field count plus known/unknown flag for a cell tag.
// Tags wider than the defined tag width are unknown if any upper bit is set.
module lisp_tag_decode
    import lisp::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] tag,
    output logic [CNT_W-1:0]      count,
    output logic                  known
);

    field_info_t info;

    always_comb begin
        info = field_count(tag[TAG_W-1:0]);
        if ((tag >> TAG_W) != '0) begin
            info.known = 1'b0;
            info.count = '0;
        end
    end

    assign count = info.count;
    assign known = info.known;

endmodule

// File: rtl/cell_fetch.sv
// Object fetch engine: reads a tagged cell from a one-cycle-latency ROM and presents it on
// a valid/ready port. Define CELL_FETCH_TYPE_CHECK_EN to flag unknown tags on rsp_err.
module cell_fetch
    import lisp::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_ptr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_tag,
    output logic [DATA_WIDTH-1:0] rsp_f0,
    output logic [DATA_WIDTH-1:0] rsp_f1,
    output logic [DATA_WIDTH-1:0] rsp_f2,
    output logic                  rsp_err,
    output fetch_state_t          dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
    // depends on ready, and the payload is held stable while valid is high and ready is low.

    fetch_state_t     state;
    logic [CNT_W-1:0] fld_idx;
    logic [CNT_W-1:0] fld_cnt;
    logic [CNT_W-1:0] dec_count;
    logic             dec_known;

    lisp_tag_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
        .tag   (mem_data),
        .count (dec_count),
        .known (dec_known)
    );

    assign dbg_state = state;

    // Mem_addr runs one word ahead of capture so each field arrives the cycle it is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            mem_addr  <= '0;
            rsp_tag   <= '0;
            rsp_f0    <= '0;
            rsp_f1    <= '0;
            rsp_f2    <= '0;
            fld_idx   <= '0;
            fld_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr  <= req_ptr;
                        rsp_tag   <= '0;
                        rsp_f0    <= '0;
                        rsp_f1    <= '0;
                        rsp_f2    <= '0;
                        req_ready <= 1'b0;
                        state     <= TAG;
                    end
                end
                TAG: begin
                    mem_addr <= mem_addr + 1'b1;
                    state    <= DECODE;
                end
                DECODE: begin
                    rsp_tag <= mem_data;
                    fld_idx <= '0;
                    fld_cnt <= dec_count;
                    if (dec_count == '0) begin
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                        state    <= FIELD;
                    end
                end
                FIELD: begin
                    case (fld_idx)
                        2'd0:    rsp_f0 <= mem_data;
                        2'd1:    rsp_f1 <= mem_data;
                        default: rsp_f2 <= mem_data;
                    endcase
                    if (fld_idx == fld_cnt - 2'd1) begin
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                        fld_idx  <= fld_idx + 2'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CELL_FETCH_TYPE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            rsp_err <= 1'b0;
        end else if (state == DECODE && !dec_known) begin
            rsp_err <= 1'b1;
        end
    end
`else
    logic unused_dec_known;
    assign unused_dec_known = dec_known;
    assign rsp_err          = 1'b0;
`endif

endmodule

// File: tb/tb_cell_fetch.sv
// Self-checking bench for cell_fetch against a one-cycle-latency behavioural ROM.
// Honours CELL_FETCH_TYPE_CHECK_EN for the unknown-tag expectation.
module tb_cell_fetch;
    import lisp::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int W  = 1 + 4 * DW;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_ptr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_tag;
    logic [DW-1:0] rsp_f0;
    logic [DW-1:0] rsp_f1;
    logic [DW-1:0] rsp_f2;
    logic          rsp_err;
    fetch_state_t  dbg_state;

    logic [DW-1:0] mem [256];
    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] addr_trace[$];
    int            checks;
    int            errors;

    cell_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ptr   (req_ptr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_tag   (rsp_tag),
        .rsp_f0    (rsp_f0),
        .rsp_f1    (rsp_f1),
        .rsp_f2    (rsp_f2),
        .rsp_err   (rsp_err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= mem[mem_addr];

    function automatic logic [W-1:0] obj(input logic err, input logic [DW-1:0] tag,
                                         input logic [DW-1:0] f0, input logic [DW-1:0] f1,
                                         input logic [DW-1:0] f2);
        return {err, tag, f0, f1, f2};
    endfunction

    function automatic logic [W-1:0] observed();
        return {rsp_err, rsp_tag, rsp_f0, rsp_f1, rsp_f2};
    endfunction

    task automatic load_image();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = NIL;
        mem[8'h01] = TYPE_NUMBER;    mem[8'h02] = 8'h12;
        mem[8'h03] = 8'h77;          mem[8'h04] = 8'h66;
        mem[8'h05] = TYPE_FUNC_PRIM; mem[8'h06] = PRIM_CONS;
        mem[8'h07] = NIL;            mem[8'h08] = NIL;
        mem[8'h09] = TYPE_CONS;      mem[8'h0A] = 8'h03;   mem[8'h0B] = NIL;
        mem[8'h0C] = 8'h5A;
        mem[8'h30] = 8'hEE;          mem[8'h31] = 8'h99;   mem[8'h32] = 8'h98;
        mem[8'hFE] = TYPE_CONS;      mem[8'hFF] = 8'hAA;
    endtask

    // ---------------- driver ----------------
    task automatic do_fetch(input logic [AW-1:0] ptr, input logic [W-1:0] expv,
                            input int exp_lat, input int hold, input string name);
        int           lat;
        logic [W-1:0] want;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready_idle got %b want 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_ptr   = ptr;
        exp_q.push_back(expv);
        addr_trace.delete();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        addr_trace.push_back(mem_addr);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            addr_trace.push_back(mem_addr);
        end while (rsp_valid !== 1'b1 && lat < 20);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
        end
        want = exp_q.pop_front();
        checks++;
        if (observed() !== want) begin
            errors++;
            $display("FAIL %s object got %h want %h", name, observed(), want);
        end
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || observed() !== want) begin
                errors++;
                $display("FAIL %s hold_cycle%0d got v=%b rr=%b obj=%h want v=1 rr=0 obj=%h",
                         name, c, rsp_valid, req_ready, observed(), want);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after_handshake got rr=%b v=%b want rr=1 v=0",
                     name, req_ready, rsp_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        checks++;
        if (rsp_valid !== 1'b0 || mem_addr !== 8'h00 || observed() !== '0) begin
            errors++;
            $display("FAIL reset_values got v=%b addr=%h obj=%h want v=0 addr=00 obj=0",
                     rsp_valid, mem_addr, observed());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_release got rr=%b state=%0d want rr=1 state=IDLE",
                     req_ready, dbg_state);
        end
    endtask

    task automatic test_number();
        do_fetch(8'h01, obj(1'b0, TYPE_NUMBER, 8'h12, 8'h00, 8'h00), 3, 0, "number");
    endtask

    task automatic test_back_to_back();
        do_fetch(8'h09, obj(1'b0, TYPE_CONS, 8'h03, NIL, 8'h00), 4, 0, "cons");
        do_fetch(8'h05, obj(1'b0, TYPE_FUNC_PRIM, PRIM_CONS, NIL, NIL), 5, 0, "func_prim");
    endtask

    task automatic test_nil();
        do_fetch(8'h00, obj(1'b0, NIL, 8'h00, 8'h00, 8'h00), 2, 0, "nil");
    endtask

    task automatic test_wrap();
        logic [AW-1:0] want_addr [4];
        want_addr[0] = 8'hFE; want_addr[1] = 8'hFF; want_addr[2] = 8'h00; want_addr[3] = 8'h01;
        mem[8'h00] = 8'h55;
        do_fetch(8'hFE, obj(1'b0, TYPE_CONS, 8'hAA, 8'h55, 8'h00), 4, 0, "wrap");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_trace.size() <= i || addr_trace[i] !== want_addr[i]) begin
                errors++;
                $display("FAIL wrap mem_addr[%0d] got %h want %h", i,
                         (addr_trace.size() > i) ? addr_trace[i] : 8'hxx, want_addr[i]);
            end
        end
        mem[8'h00] = NIL;
    endtask

    task automatic test_backpressure();
        do_fetch(8'h01, obj(1'b0, TYPE_NUMBER, 8'h12, 8'h00, 8'h00), 3, 10, "backpressure");
    endtask

    task automatic test_reset_mid_fetch();
        int seen_valid;
        @(negedge clk);
        req_valid = 1'b1;
        req_ptr   = 8'h09;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dbg_state !== FIELD) begin
            errors++;
            $display("FAIL mid_reset pre_state got %0d want FIELD", dbg_state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || mem_addr !== 8'h00 || observed() !== '0 ||
            dbg_state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset values got v=%b addr=%h obj=%h state=%0d want 0/00/0/IDLE",
                     rsp_valid, mem_addr, observed(), dbg_state);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) seen_valid++;
        end
        checks++;
        if (seen_valid != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset discard got valid_cycles=%0d rr=%b want 0/1",
                     seen_valid, req_ready);
        end
        do_fetch(8'h01, obj(1'b0, TYPE_NUMBER, 8'h12, 8'h00, 8'h00), 3, 0, "after_reset");
    endtask

    task automatic test_unknown_tag();
`ifdef CELL_FETCH_TYPE_CHECK_EN
        do_fetch(8'h30, obj(1'b1, 8'hEE, 8'h00, 8'h00, 8'h00), 2, 0, "unknown_tag");
        do_fetch(8'h01, obj(1'b0, TYPE_NUMBER, 8'h12, 8'h00, 8'h00), 3, 0, "err_clear");
`else
        do_fetch(8'h30, obj(1'b0, 8'hEE, 8'h00, 8'h00, 8'h00), 2, 0, "unknown_tag");
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_ptr   = '0;
        rsp_ready = 1'b0;
        load_image();
        test_reset();
        test_number();
        test_back_to_back();
        test_nil();
        test_wrap();
        test_backpressure();
        test_reset_mid_fetch();
        test_unknown_tag();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cell_fetch.md
# cell_fetch

Object fetch engine sitting directly downstream of the synchronous cell ROM. Given a pointer to a tagged Lisp cell, it reads the tag word, determines the field count from the tag, and streams the remaining words out of the ROM. It then presents the whole decoded object on a valid/ready response port to the evaluator.

## Interface
- ADDR_WIDTH, 8, ROM address width; pointers are ADDR_WIDTH bits.
- DATA_WIDTH, 8, ROM word width; tags and fields are DATA_WIDTH bits.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request pointer valid.
- req_ready  out  1  block can accept a request.
- req_ptr  in  ADDR_WIDTH  address of the cell's tag word.
- mem_addr  out  ADDR_WIDTH  registered ROM address.
- mem_data  in  DATA_WIDTH  ROM read data, one-cycle registered latency.
- rsp_valid  out  1  fetched object valid.
- rsp_ready  in  1  consumer accepts the object.
- rsp_tag  out  DATA_WIDTH  cell tag.
- rsp_f0, rsp_f1, rsp_f2  out  DATA_WIDTH  cell fields in address order; unused fields read 0.
- rsp_err  out  1  unknown tag; present only when CELL_FETCH_TYPE_CHECK_EN is defined, otherwise tied 0.

## Operation
- One clock domain. Reset is asynchronous and active-low.
- Field counts per tag:
  - lisp::NIL: 0 fields.
  - lisp::TYPE_NUMBER: 1 field (value).
  - lisp::TYPE_CONS: 2 fields (car, cdr pointers).
  - lisp::TYPE_FUNC_PRIM: 3 fields.
- States and transitions:
  - IDLE: req_ready=1. A request handshake loads mem_addr<=req_ptr, clears all rsp fields and goes to TAG.
  - TAG: ROM is reading the tag. mem_addr<=mem_addr+1 (speculative prefetch of field 0). Go to DECODE.
  - DECODE: capture mem_data into rsp_tag and load the field count n. If n=0, go to DONE. Otherwise mem_addr<=mem_addr+1 and go to FIELD.
  - FIELD: capture mem_data into rsp_f[k], where k counts 0..n-1. Keep incrementing mem_addr while words remain. After capturing k=n-1, go to DONE.
  - DONE: rsp_valid=1 and all rsp outputs stable. A handshake (rsp_valid && rsp_ready) returns to IDLE.
- req_ready is high only in IDLE, so there is never more than one object in flight.
- Address arithmetic is modulo 2^ADDR_WIDTH; a cell at the top of memory wraps its fields to 0x00.
- Speculative reads past the cell end are harmless and never alter outputs.
- Reset values, also applied on reset mid-fetch: state IDLE, req_ready=1 after release, rsp_valid=0, mem_addr=0, rsp_tag/f0/f1/f2=0, rsp_err=0. A fetch interrupted by reset is discarded, never completed.

## Timing
- Request accepted at edge E0. The tag is captured at edge E2.
- Field k is captured at edge E(3+k).
- rsp_valid rises after edge E(2+n): 2 cycles for NIL, 3 for NUMBER, 4 for CONS, 5 for FUNC_PRIM.
- rsp_valid holds indefinitely under backpressure.
- req_ready rises the cycle after the response handshake, so back-to-back throughput is one object per (n+4) cycles.
- mem_addr changes only on clock edges; the ROM sees a stable address for a full cycle.

## Configuration
- CELL_FETCH_TYPE_CHECK_EN defined:
  - An unrecognised tag in DECODE sets rsp_err=1 and n=0, then goes to DONE.
  - rsp_err clears on the next request acceptance.
- Not defined:
  - Unrecognised tags are treated as 0-field cells and rsp_err is constant 0.
  - No check logic is synthesised.

## Structure
- Shared lisp package holds:
  - the tag constants (already present);
  - a new function field_count(tag) returning 0..3 plus a known/unknown flag;
  - MAX_FIELDS=3;
  - the fetch state enum (IDLE, TAG, DECODE, FIELD, DONE).
- Optional combinational sub-module lisp_tag_decode wraps field_count so the evaluator can reuse it.
- The rest is one FSM plus a field-index counter.

## Test plan
Bench uses a one-cycle-latency behavioural memory preloaded with this image:
- 0x00 NIL
- 0x01 NUMBER,0x12
- 0x05 FUNC_PRIM,PRIM_CONS,NIL,NIL
- 0x09 CONS,0x03,NIL
- 0xFE CONS,0xAA,0x55 with 0x00 holding 0x55

Scenarios:
- req_ptr=0x01 -> rsp_tag=NUMBER, f0=0x12, f1=f2=0, rsp_valid 3 cycles after acceptance.
- req_ptr=0x09 -> rsp_tag=CONS, f0=0x03, f1=NIL, latency 4. Then req_ptr=0x05 -> FUNC_PRIM, f0=PRIM_CONS, f1=f2=NIL, latency 5.
- req_ptr=0x00 -> rsp_tag=NIL, all fields 0, latency 2.
- req_ptr=0xFE -> mem_addr sequence FE,FF,00,01; f0=0xAA, f1=0x55.
- rsp_ready held low 10 cycles -> rsp_valid and outputs stable, req_ready=0 throughout. Assert rsp_ready -> req_ready=1 next cycle.
- Reset asserted in FIELD state -> outputs at reset values immediately. After release, a new req_ptr=0x01 returns NUMBER/0x12. With CELL_FETCH_TYPE_CHECK_EN, a tag of 0xEE -> rsp_err=1, fields 0, latency 2.
